// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - single-outstanding cache memory port to single-beat AXI bridge
module axi_mem_responder #(
    parameter int         A_WIDTH = 32,
    parameter logic [3:0] AXI_ID  = 4'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A_WIDTH-1:0] m_a,
    input  logic [31:0]        m_din,
    output logic [31:0]        m_dout,
    input  logic               m_strobe,
    input  logic               m_rw,
    input  logic [3:0]         m_wen,
    input  logic [1:0]         m_size,
    output logic               m_ready,
    output logic [3:0]         arid,
    output logic [A_WIDTH-1:0] araddr,
    output logic [2:0]         arsize,
    output logic               arvalid,
    input  logic               arready,
    input  logic [31:0]        rdata,
    input  logic [1:0]         rresp,
    input  logic               rlast,
    input  logic               rvalid,
    output logic               rready,
    output logic [3:0]         awid,
    output logic [A_WIDTH-1:0] awaddr,
    output logic [2:0]         awsize,
    output logic               awvalid,
    input  logic               awready,
    output logic [31:0]        wdata,
    output logic [3:0]         wstrb,
    output logic               wlast,
    output logic               wvalid,
    input  logic               wready,
    input  logic [1:0]         bresp,
    input  logic               bvalid,
    output logic               bready,
    output logic               bus_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WREQ  = 3'd3,
        S_WRESP = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [A_WIDTH-1:0] r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wstrb;
    logic [1:0]         r_size;
    logic [31:0]        r_rdata;
    logic               r_aw_done;
    logic               r_w_done;
    logic               r_bus_err;

    logic               w_accept;
    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_aw_all;
    logic               w_w_all;
    logic               w_r_hs;
    logic               w_b_hs;

    // Reads are always single-beat, so rlast carries no extra information.
    logic               w_unused_rlast;
    assign w_unused_rlast = rlast;

    // Every AXI-facing output is decoded from state and request registers only.
    assign arid    = AXI_ID;
    assign awid    = AXI_ID;
    assign araddr  = r_addr;
    assign awaddr  = r_addr;
    assign arsize  = {1'b0, r_size};
    assign awsize  = {1'b0, r_size};
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wlast   = 1'b1;
    assign arvalid = (r_state == S_RADDR);
    assign rready  = (r_state == S_RDATA);
    assign awvalid = (r_state == S_WREQ) && !r_aw_done;
    assign wvalid  = (r_state == S_WREQ) && !r_w_done;
    assign bready  = (r_state == S_WRESP);
    assign m_ready = (r_state == S_DONE);
    assign m_dout  = r_rdata;
    assign bus_err = r_bus_err;

    assign w_accept = (r_state == S_IDLE) && m_strobe;
    assign w_aw_hs  = awvalid && awready;
    assign w_w_hs   = wvalid && wready;
    assign w_aw_all = r_aw_done || w_aw_hs;
    assign w_w_all  = r_w_done || w_w_hs;
    assign w_r_hs   = rready && rvalid;
    assign w_b_hs   = bready && bvalid;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; DONE never looks at m_strobe so a held request is not re-issued.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (m_strobe) begin
                    w_next = m_rw ? S_WREQ : S_RADDR;
                end
            end
            S_RADDR: begin
                if (arready) begin
                    w_next = S_RDATA;
                end
            end
            S_RDATA: begin
                if (rvalid) begin
                    w_next = S_DONE;
                end
            end
            S_WREQ: begin
                if (w_aw_all && w_w_all) begin
                    w_next = S_WRESP;
                end
            end
            S_WRESP: begin
                if (bvalid) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Capture the request when it is accepted so the AXI side never sees m_* change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_size  <= '0;
        end else if (w_accept) begin
            r_addr  <= m_a;
            r_wdata <= m_din;
            r_wstrb <= m_wen;
            r_size  <= m_size;
        end
    end

    // Track AW and W acceptance independently; either may finish first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (w_accept) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end
        end
    end

    // Load data is held until the next read completes; writes leave it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_r_hs) begin
            r_rdata <= rdata;
        end
    end

    // Sticky error flag for any non-OKAY read or write response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_err <= 1'b0;
        end else if ((w_r_hs && (rresp != 2'b00)) || (w_b_hs && (bresp != 2'b00))) begin
            r_bus_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// tb/tb_axi_mem_responder.sv - directed self-checking bench for axi_mem_responder
module tb_axi_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m_a = '0;
    logic [31:0] m_din = '0;
    logic [31:0] m_dout;
    logic        m_strobe = 1'b0;
    logic        m_rw = 1'b0;
    logic [3:0]  m_wen = '0;
    logic [1:0]  m_size = '0;
    logic        m_ready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = '0;
    logic        bvalid = 1'b0;
    logic        bready;
    logic        bus_err;

    axi_mem_responder #(.A_WIDTH(32), .AXI_ID(4'd0)) dut (
        .clk(clk), .rst(rst),
        .m_a(m_a), .m_din(m_din), .m_dout(m_dout), .m_strobe(m_strobe),
        .m_rw(m_rw), .m_wen(m_wen), .m_size(m_size), .m_ready(m_ready),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // slave configuration
    int          ar_wait, r_wait, aw_wait, w_wait, b_wait;
    logic [31:0] rd_val;
    logic [1:0]  rresp_val, bresp_val;

    // per-request observations
    int          done_cyc, b_hs_cyc, ar_cyc, rr_cyc, aw_cyc, w_cyc, ar_rise;
    int          tot_ar_hs, tot_aw_hs;
    logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
    logic [2:0]  cap_arsize, cap_awsize;
    logic [3:0]  cap_wstrb;

    task automatic set_slave(input int arw, input int rw_, input int aww, input int ww, input int bw);
        ar_wait = arw; r_wait = rw_; aw_wait = aww; w_wait = ww; b_wait = bw;
    endtask

    // Issue one request and play a slave with the configured wait states.
    // Cycle 0 is the cycle in which the request is first presented.
    task automatic run_req(input logic rw, input logic [31:0] addr, input logic [31:0] din,
                           input logic [3:0] wen, input logic [1:0] size, input bit keep);
        int   ac, rc, awc, wc, bc;
        logic prev_ar;
        bit   done;
        ac = 0; rc = 0; awc = 0; wc = 0; bc = 0; prev_ar = 1'b0; done = 1'b0;
        done_cyc = -1; b_hs_cyc = -1; ar_cyc = 0; rr_cyc = 0; aw_cyc = 0; w_cyc = 0; ar_rise = 0;
        m_strobe = 1'b1; m_rw = rw; m_a = addr; m_din = din; m_wen = wen; m_size = size;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(posedge clk); #1;
            if (m_ready) begin
                done = 1'b1;
                done_cyc = cyc;
            end
            if (arvalid && !prev_ar) ar_rise++;
            prev_ar = arvalid;
            if (arvalid) begin ar_cyc++; cap_araddr = araddr; cap_arsize = arsize; end
            if (awvalid) begin aw_cyc++; cap_awaddr = awaddr; cap_awsize = awsize; end
            if (wvalid)  begin w_cyc++; cap_wdata = wdata; cap_wstrb = wstrb; end
            if (rready)  rr_cyc++;
            arready = arvalid && (ac >= ar_wait);
            if (arvalid) ac++;
            rvalid = rready && (rc >= r_wait);
            if (rready) rc++;
            rdata = rvalid ? rd_val : 32'h0;
            rresp = rvalid ? rresp_val : 2'b00;
            rlast = rvalid;
            awready = awvalid && (awc >= aw_wait);
            if (awvalid) awc++;
            wready = wvalid && (wc >= w_wait);
            if (wvalid) wc++;
            bvalid = bready && (bc >= b_wait);
            if (bready) bc++;
            bresp = bvalid ? bresp_val : 2'b00;
            if (bvalid) b_hs_cyc = cyc;
            if (arvalid && arready) tot_ar_hs++;
            if (awvalid && awready) tot_aw_hs++;
        end
        if (!done) check("timeout", 64'd0, 64'd1);
        if (!keep) m_strobe = 1'b0;
        @(posedge clk); #1;
        check("ready_pulse", {63'd0, m_ready}, 64'd0);
    endtask

    initial begin
        rd_val = '0; rresp_val = 2'b00; bresp_val = 2'b00;
        tot_ar_hs = 0; tot_aw_hs = 0;
        set_slave(0, 0, 0, 0, 0);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valids", {58'd0, arvalid, awvalid, wvalid, rready, bready, m_ready}, 64'd0);
        check("rst_dout", {32'd0, m_dout}, 64'd0);
        check("rst_bus_err", {63'd0, bus_err}, 64'd0);
        check("rst_araddr", {32'd0, araddr}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // word read, zero-wait slave
        rd_val = 32'hDEADBEEF;
        run_req(1'b0, 32'h1FC0_0010, 32'h0, 4'h0, 2'd2, 1'b0);
        check("rd_latency", done_cyc, 64'd3);
        check("rd_araddr", {32'd0, cap_araddr}, 64'h1FC0_0010);
        check("rd_arsize", {61'd0, cap_arsize}, 64'd2);
        check("rd_dout", {32'd0, m_dout}, 64'hDEADBEEF);
        check("rd_arid", {60'd0, arid}, 64'd0);

        // byte write, AW accepted 3 cycles late, W at once, B one cycle late
        set_slave(0, 0, 3, 0, 1);
        run_req(1'b1, 32'h0000_2000, 32'h00AB_0000, 4'b0100, 2'd0, 1'b0);
        check("wr_latency", done_cyc, 64'd7);
        check("wr_aw_cycles", aw_cyc, 64'd4);
        check("wr_w_cycles", w_cyc, 64'd1);
        check("wr_wstrb", {60'd0, cap_wstrb}, 64'b0100);
        check("wr_awsize", {61'd0, cap_awsize}, 64'd0);
        check("wr_wdata", {32'd0, cap_wdata}, 64'h00AB_0000);
        check("wr_awaddr", {32'd0, cap_awaddr}, 64'h2000);
        check("wr_b_to_ready", done_cyc - b_hs_cyc, 64'd1);
        check("wr_keeps_dout", {32'd0, m_dout}, 64'hDEADBEEF);

        // write with W accepted after AW
        set_slave(0, 0, 0, 2, 0);
        run_req(1'b1, 32'h0000_3000, 32'h1234_5678, 4'hF, 2'd2, 1'b0);
        check("wskew_latency", done_cyc, 64'd5);
        check("wskew_aw_cycles", aw_cyc, 64'd1);
        check("wskew_w_cycles", w_cyc, 64'd3);

        // read stall: arready 2 late, rvalid 5 late
        set_slave(2, 5, 0, 0, 0);
        rd_val = 32'hCAFE_F00D;
        run_req(1'b0, 32'h0000_4004, 32'h0, 4'h0, 2'd1, 1'b0);
        check("stall_latency", done_cyc, 64'd10);
        check("stall_ar_cycles", ar_cyc, 64'd3);
        check("stall_ar_rises", ar_rise, 64'd1);
        check("stall_rready_cycles", rr_cyc, 64'd6);
        check("stall_arsize", {61'd0, cap_arsize}, 64'd1);
        check("stall_dout", {32'd0, m_dout}, 64'hCAFE_F00D);

        // back-to-back write then read of 0x100, m_strobe held through DONE
        set_slave(0, 0, 0, 0, 0);
        tot_ar_hs = 0; tot_aw_hs = 0;
        rd_val = 32'h0BAD_F00D;
        run_req(1'b1, 32'h0000_0100, 32'h5555_AAAA, 4'hF, 2'd2, 1'b1);
        check("b2b_wr_latency", done_cyc, 64'd3);
        check("b2b_wr_keeps_dout", {32'd0, m_dout}, 64'hCAFE_F00D);
        run_req(1'b0, 32'h0000_0100, 32'h0, 4'h0, 2'd2, 1'b0);
        check("b2b_rd_latency", done_cyc, 64'd3);
        check("b2b_aw_count", tot_aw_hs, 64'd1);
        check("b2b_ar_count", tot_ar_hs, 64'd1);
        check("b2b_dout", {32'd0, m_dout}, 64'h0BAD_F00D);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_no_dup", {60'd0, arvalid, awvalid, wvalid, m_ready}, 64'd0);

        // read error is sticky across later OKAY traffic
        rresp_val = 2'b10;
        rd_val = 32'h1111_2222;
        run_req(1'b0, 32'h0000_0200, 32'h0, 4'h0, 2'd2, 1'b0);
        check("err_set", {63'd0, bus_err}, 64'd1);
        rresp_val = 2'b00;
        run_req(1'b1, 32'h0000_0204, 32'h7, 4'h1, 2'd0, 1'b0);
        check("err_sticky_wr", {63'd0, bus_err}, 64'd1);
        run_req(1'b0, 32'h0000_0208, 32'h0, 4'h0, 2'd2, 1'b0);
        check("err_sticky_rd", {63'd0, bus_err}, 64'd1);

        // reset while stuck in the write request phase
        set_slave(0, 0, 100, 100, 0);
        m_strobe = 1'b1; m_rw = 1'b1; m_a = 32'h0000_0300; m_din = 32'hFFFF_0000;
        m_wen = 4'hC; m_size = 2'd1;
        @(posedge clk); #1;
        check("mid_awvalid", {62'd0, awvalid, wvalid}, 64'b11);
        @(posedge clk); #1;
        rst = 1'b1; m_strobe = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_outs", {59'd0, awvalid, wvalid, bready, m_ready, arvalid}, 64'd0);
        check("mid_rst_bus_err", {63'd0, bus_err}, 64'd0);
        check("mid_rst_dout", {32'd0, m_dout}, 64'd0);
        rst = 1'b0;
        set_slave(0, 0, 0, 0, 0);
        rd_val = 32'h600D_0001;
        run_req(1'b0, 32'h0000_0400, 32'h0, 4'h0, 2'd2, 1'b0);
        check("post_rst_latency", done_cyc, 64'd3);
        check("post_rst_dout", {32'd0, m_dout}, 64'h600D_0001);

        // write response error also sets the flag
        bresp_val = 2'b11;
        run_req(1'b1, 32'h0000_0404, 32'h1, 4'h1, 2'd0, 1'b0);
        check("berr_set", {63'd0, bus_err}, 64'd1);
        bresp_val = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
